sample_rate_restore: RTL and testbench
======================================

Name: sample_rate_restore

Overview:
- Inverse of the rate-switch path: takes a stereo stream at one of eight rates (1536k down to 12k) and restores it to a fixed 48 kHz output on sample_clk (12.288 MHz).
- Rates above 48k: boxcar-averaged and decimated. Rates below 48k: zero-order-hold upsampled.
- A small FIFO decouples the input arrival phase from the 48k output tick.
- Sits after the filter bank, ahead of the 48k codec/I2S output.

Parameters:
- CH_BITS, 16, signed bits per channel; data word is 2*CH_BITS, with the left channel in the low half.
- FIFO_DEPTH, 4, entries in the restore FIFO (power of 2, ≥2).
- TICK_DIV, 256, sample_clk cycles per 48k output tick.
- PRIME_LEVEL, 2, FIFO occupancy required before output ticks start.

Ports:
- sample_clk  in  1  12.288 MHz clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rate_sel  in  3  input-rate code: 0:1536k 1:768k 2:384k 3:192k 4:96k 5:48k 6:24k 7:12k.
- in_valid  in  1  one-cycle strobe; in_data is valid on this cycle.
- in_data  in  2*CH_BITS  signed stereo input sample.
- out_valid  out  1  one-cycle pulse at each 48k tick while in RUN.
- out_data  out  2*CH_BITS  restored 48k sample; held between pulses.
- running  out  1  high while in state RUN.
- underflow  out  1  sticky flag: FIFO empty at a pop tick.
- overflow  out  1  sticky flag: push attempted while FIFO full.

Behaviour:
- Reset (asynchronous): out_valid=0, out_data=0, running=0, underflow=0, overflow=0. Accumulators, FIFO pointers and the tick counter clear. State goes to SYNC.
- Rate decode:
  - k<5: decimation, D = 2^(5-k), so D=32 at k=0 and D=2 at k=4.
  - k=5: pass-through, D=1.
  - k>5: upsampling, U = 2^(k-5), so U=2 at k=6 and U=4 at k=7.
- Accumulate stage (k≤5):
  - Per-channel signed accumulator, CH_BITS+5 bits wide, sign-extended on add.
  - A phase counter counts in_valid strobes 0..D-1.
  - On the D-th strobe: push (acc + current sample) >>> (5-k) per channel, then clear acc and the phase counter in the same cycle.
  - Arithmetic shift; truncate toward -inf unless the optional feature is enabled.
- Upsample stage (k>5): each in_valid pushes in_data unchanged.
- Push latency: the FIFO entry is written on the cycle after the qualifying in_valid.
- FIFO: synchronous, FIFO_DEPTH entries.
  - Push when full: the new word is dropped and overflow is set.
  - Simultaneous push and pop: both occur; occupancy is unchanged.
- State machine:
  - SYNC: tick counter held at 0; out_valid=0; running=0. Go to RUN when occupancy ≥ PRIME_LEVEL.
  - RUN: tick counter runs 0..TICK_DIV-1 and wraps. A tick fires on the cycle count==TICK_DIV-1; out_valid=1 on that same cycle. running=1.
- Tick handling (in RUN):
  - Hold counter runs 0..U-1 (U=1 for k≤5).
  - When hold==0: pop and load out_data with the popped word.
  - When hold≠0: out_data repeats the previous value; no pop.
  - If a pop is due and the FIFO is empty: out_data repeats, out_valid still pulses, underflow is set, and the state stays RUN.
  - The first tick after entering RUN is a pop tick.
- Rate change: rate_sel is sampled each cycle; a change is a difference from the previous cycle's value. On that cycle:
  - Clear accumulators, phase, hold counter, tick counter and FIFO.
  - Go to SYNC. out_data holds its last value.
  - An in_valid on the change cycle is discarded.
- Sticky flags: cleared only by reset.

Optional Feature:
- Macro: SAMPLE_RESTORE_ROUND_EN.
- Defined: in decimation, add 2^(4-k) to each channel sum before the shift (round half up). Not applied at k=5, since the shift is 0.
- Undefined: plain arithmetic-shift truncation.

Test Plan:
- Pass-through: rate_sel=5, in_valid every 256 cycles, data 0x0001_FFFF, 0x0002_FFFE, ... → running after 2 pushes; out_valid every 256 cycles; out_data equals inputs in order; no flags.
- Decimate by 32: rate_sel=0, in_valid every 8 cycles, each channel constant 100 → out_data=0x0064_0064. Then L=+1 on 31 samples and 0 on one → L=0 truncated, L=1 with SAMPLE_RESTORE_ROUND_EN.
- Negative sums: rate_sel=4 (D=2), L inputs -3 then -4 → L output -4 truncated (0xFFFC), -3 with rounding.
- Upsample by 4: rate_sel=7, inputs A, B every 1024 cycles → out_data sequence A,A,A,A,B,B,B,B on consecutive ticks.
- Underflow and overflow: stop inputs in RUN → after FIFO drains, out_data repeats and underflow=1. Burst 6 strobes at rate_sel=5 with ticks stalled in SYNC → overflow=1 and occupancy=4.
- Rate change and reset: switch rate_sel 5→1 mid-stream → next cycle running=0, FIFO empty, out_data held. Assert reset_n low mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sample_rate_restore.sv
// Restores a stereo stream at one of eight input rates to a 48 kHz output.
// Optional SAMPLE_RESTORE_ROUND_EN: round half up before the decimation shift.
module sample_rate_restore #(
  parameter int CH_BITS     = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TICK_DIV    = 256,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                   sample_clk,
  input  logic                   reset_n,
  input  logic [2:0]             rate_sel,
  input  logic                   in_valid,
  input  logic [2*CH_BITS-1:0]   in_data,
  output logic                   out_valid,
  output logic [2*CH_BITS-1:0]   out_data,
  output logic                   running,
  output logic                   underflow,
  output logic                   overflow
);

  localparam int AW = CH_BITS + 5;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = 2 * CH_BITS;

  localparam logic [0:0] S_SYNC = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [2:0]           rate_q;
  logic                 chg;
  logic                 decim;
  logic [2:0]           shamt;
  logic [4:0]           phase_last;
  logic [1:0]           hold_last;

  logic signed [AW-1:0] acc_l_q, acc_r_q;
  logic signed [AW-1:0] sum_l, sum_r, rnd, res_l, res_r;
  logic [4:0]           phase_q;
  logic                 push_q;
  logic [DW-1:0]        push_data_q;

  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [PW:0]          cnt_q;
  logic                 full, empty, push_ok;

  logic [0:0]           state_q, state_d;
  logic [TW-1:0]        tick_q;
  logic [1:0]           hold_q;
  logic                 tick, pop_due, pop;
  logic [DW-1:0]        data_q;
  logic                 uf_q, of_q;

  // Rate decode and change detection against last cycle's code.
  always_comb begin
    chg        = rate_sel != rate_q;
    decim      = rate_sel <= 3'd5;
    shamt      = decim ? 3'd5 - rate_sel : 3'd0;
    phase_last = 5'((6'd1 << shamt) - 6'd1);
    unique case (rate_sel)
      3'd6:    hold_last = 2'd1;
      3'd7:    hold_last = 2'd3;
      default: hold_last = 2'd0;
    endcase
  end

  // Per-channel sum including the current sample, rounded and shifted.
  always_comb begin
    sum_l = acc_l_q + {{5{in_data[CH_BITS-1]}}, in_data[CH_BITS-1:0]};
    sum_r = acc_r_q + {{5{in_data[DW-1]}}, in_data[DW-1:CH_BITS]};
`ifdef SAMPLE_RESTORE_ROUND_EN
    rnd = (shamt != 3'd0) ? (AW'(1) << (shamt - 3'd1)) : '0;
`else
    rnd = '0;
`endif
    res_l = (sum_l + rnd) >>> shamt;
    res_r = (sum_r + rnd) >>> shamt;
  end

  // Accumulate or pass samples into a one-cycle push register.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_q      <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      phase_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      rate_q <= rate_sel;
      push_q <= 1'b0;
      if (chg) begin
        acc_l_q <= '0;
        acc_r_q <= '0;
        phase_q <= '0;
      end else if (in_valid) begin
        if (!decim) begin
          push_q      <= 1'b1;
          push_data_q <= in_data;
        end else if (phase_q == phase_last) begin
          push_q      <= 1'b1;
          push_data_q <= {res_r[CH_BITS-1:0], res_l[CH_BITS-1:0]};
          acc_l_q     <= '0;
          acc_r_q     <= '0;
          phase_q     <= '0;
        end else begin
          acc_l_q <= sum_l;
          acc_r_q <= sum_r;
          phase_q <= phase_q + 5'd1;
        end
      end
    end
  end

  // Tick, pop and push qualification.
  always_comb begin
    full    = cnt_q == (PW+1)'(FIFO_DEPTH);
    empty   = cnt_q == '0;
    tick    = (state_q == S_RUN) && (tick_q == TW'(TICK_DIV - 1)) && !chg;
    pop_due = tick && (hold_q == 2'd0);
    pop     = pop_due && !empty;
    push_ok = push_q && !chg && (!full || pop);
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge sample_clk) begin
    if (push_ok) mem[wr_q] <= push_data_q;
  end

  // FIFO pointers and occupancy; a rate change empties it.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (chg) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop)     rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end

  // Next state: prime in SYNC, run until the rate changes.
  always_comb begin
    state_d = state_q;
    if (chg)
      state_d = S_SYNC;
    else if (state_q == S_SYNC && cnt_q >= (PW+1)'(PRIME_LEVEL))
      state_d = S_RUN;
  end

  // Output tick counter, hold counter, output word and sticky flags.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_SYNC;
      tick_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (chg || state_q == S_SYNC)
        tick_q <= '0;
      else if (tick_q == TW'(TICK_DIV - 1))
        tick_q <= '0;
      else
        tick_q <= tick_q + TW'(1);
      if (chg)
        hold_q <= '0;
      else if (tick)
        hold_q <= (hold_q == hold_last) ? 2'd0 : hold_q + 2'd1;
      if (pop) data_q <= mem[rd_q];
      if (pop_due && empty) uf_q <= 1'b1;
      if (push_q && !chg && full && !pop) of_q <= 1'b1;
    end
  end

  assign out_valid = tick;
  assign out_data  = pop ? mem[rd_q] : data_q;
  assign running   = state_q == S_RUN;
  assign underflow = uf_q;
  assign overflow  = of_q;

endmodule

// File: tb/tb_sample_rate_restore.sv
// Randomized bench for sample_rate_restore with a queue-based reference.
// Model tracks decimation sums, a 4-deep FIFO and the 256-cycle tick.
module tb_sample_rate_restore;

`ifdef SAMPLE_RESTORE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  rate_sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        running;
  logic        underflow;
  logic        overflow;

  int n_chk;
  int n_err;

  sample_rate_restore dut (
    .sample_clk (clk),
    .reset_n    (reset_n),
    .rate_sel   (rate_sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .running    (running),
    .underflow  (underflow),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int s);
    int d, q;
    d = 1 << s;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  logic [31:0] mq[$];
  logic [31:0] m_last;
  logic [31:0] m_pd;
  bit          m_pv, m_run, m_uf, m_of;
  int          m_tc, m_rep, m_sl, m_sr, m_n, m_prev;

  task automatic mreset();
    mq.delete();
    m_last = '0;
    m_pd   = '0;
    m_pv   = 0;
    m_run  = 0;
    m_uf   = 0;
    m_of   = 0;
    m_tc   = 0;
    m_rep  = 0;
    m_sl   = 0;
    m_sr   = 0;
    m_n    = 0;
    m_prev = int'(rate_sel);
  endtask

  always @(negedge clk) begin
    int   k, occ, s, u, rl, rr;
    bit   chg, ev;
    logic [31:0] ed;
    logic [15:0] l16, r16;
    if (!reset_n) begin
      mreset();
    end else begin
      k = int'(rate_sel);
      chg = (k != m_prev);
      m_prev = k;
      u = (k > 5) ? (1 << (k - 5)) : 1;
      ev = m_run && (m_tc == 255) && !chg;
      ed = m_last;
      if (ev && m_rep == 0 && mq.size() > 0) ed = mq[0];
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("out_data", out_data, ed);
      chk("running", {31'd0, running}, {31'd0, m_run});
      chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
      chk("overflow", {31'd0, overflow}, {31'd0, m_of});
      if (chg) begin
        mq.delete();
        m_pv  = 0;
        m_sl  = 0;
        m_sr  = 0;
        m_n   = 0;
        m_rep = 0;
        m_run = 0;
        m_tc  = 0;
      end else begin
        occ = mq.size();
        if (ev) begin
          if (m_rep == 0) begin
            if (mq.size() > 0) m_last = mq.pop_front();
            else m_uf = 1;
            m_rep = u - 1;
          end else begin
            m_rep--;
          end
        end
        if (m_pv) begin
          if (mq.size() < 4) mq.push_back(m_pd);
          else m_of = 1;
        end
        m_pv = 0;
        if (!m_run) begin
          if (occ >= 2) begin
            m_run = 1;
            m_tc  = 0;
          end
        end else begin
          m_tc = (m_tc + 1) % 256;
        end
        if (in_valid) begin
          if (k <= 5) begin
            s = 5 - k;
            m_sl += $signed(in_data[15:0]);
            m_sr += $signed(in_data[31:16]);
            m_n++;
            if (m_n == (1 << s)) begin
              rl = m_sl + ((RND && s > 0) ? (1 << (s - 1)) : 0);
              rr = m_sr + ((RND && s > 0) ? (1 << (s - 1)) : 0);
              l16 = 16'(fdiv(rl, s));
              r16 = 16'(fdiv(rr, s));
              m_pv = 1;
              m_pd = {r16, l16};
              m_sl = 0;
              m_sr = 0;
              m_n  = 0;
            end
          end else begin
            m_pv = 1;
            m_pd = in_data;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input int per);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
    repeat (per - 1) cyc();
  endtask

  function automatic logic [31:0] rnd32();
    return $urandom;
  endfunction

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    rate_sel = 3'd5;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);
    chk("rst_of", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    repeat (3) cyc();

    for (int i = 1; i <= 10; i++)
      send({16'(i), 16'(-i)}, 256);
    chk("pt_running", {31'd0, running}, 32'd1);

    rate_sel = 3'd1;
    cyc();
    chk("chg_running", {31'd0, running}, 32'd0);
    repeat (20) cyc();

    rate_sel = 3'd0;
    cyc();
    for (int i = 0; i < 32; i++)
      send({16'd100, 16'd100}, 8);
    for (int i = 0; i < 32; i++)
      send({16'd0, (i < 31) ? 16'd1 : 16'd0}, 8);
    for (int i = 0; i < 32 * 8; i++)
      send(rnd32(), 8);

    rate_sel = 3'd4;
    cyc();
    send({16'd7, 16'hFFFD}, 128);
    send({16'd8, 16'hFFFC}, 128);
    for (int i = 0; i < 16; i++)
      send(rnd32(), 128);

    rate_sel = 3'd7;
    cyc();
    for (int i = 0; i < 6; i++)
      send(rnd32(), 1024);

    rate_sel = 3'd6;
    cyc();
    for (int i = 0; i < 6; i++)
      send(rnd32(), 512);

    rate_sel = 3'd5;
    cyc();
    for (int i = 0; i < 6; i++)
      send(rnd32(), 256);
    repeat (1500) cyc();
    chk("uf_after_drain", {31'd0, underflow}, 32'd1);
    chk("of_before_burst", {31'd0, overflow}, 32'd0);

    rate_sel = 3'd4;
    cyc();
    rate_sel = 3'd5;
    cyc();
    for (int i = 0; i < 6; i++)
      send(rnd32(), 1);
    repeat (1500) cyc();
    chk("of_after_burst", {31'd0, overflow}, 32'd1);
    chk("run_before_rst", {31'd0, running}, 32'd1);

    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_running", {31'd0, running}, 32'd0);
    chk("arst_uf", {31'd0, underflow}, 32'd0);
    chk("arst_of", {31'd0, overflow}, 32'd0);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (5) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
